cavlc_coeff_scan: RTL and testbench

Downstream consumer of the intra 4x4 luma stage. It accepts one quantised 4x4 residual block per handshake, zig-zag scans it in reverse order at one coefficient per cycle, and emits the CAVLC symbol set: TotalCoeff, TrailingOnes, trailing-one signs, TotalZeros, levels and run_before values. It drives the `cavlc_cnt_ready` handshake that releases the intra stage's WAIT_CAVLC state, and feeds the CAVLC bitstream packer.

---
 rtl/cavlc_coeff_scan.sv | 156 +++++++++++++++
 tb/tb_cavlc_coeff_scan.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cavlc_coeff_scan.sv
// cavlc_coeff_scan: accepts one quantised 4x4 block, walks it in reverse zig-zag order
// (one coefficient per cycle) and produces the CAVLC symbol set for the bitstream packer.
module cavlc_coeff_scan (
  input  logic               clk,
  input  logic               rst,
  input  logic               h264_reset,
  input  logic               dctq_valid_i,
  input  logic signed [14:0] dctq_i [0:3][0:3],
  input  logic [9:0]         topleft_x_i,
  input  logic [9:0]         topleft_y_i,
  output logic               cnt_ready_o,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [4:0]         total_coeff_o,
  output logic [1:0]         trailing_ones_o,
  output logic [2:0]         t1_signs_o,
  output logic [3:0]         total_zeros_o,
  output logic signed [14:0] level_o [0:15],
  output logic [3:0]         run_o [0:15],
  output logic [9:0]         blk_x_o,
  output logic [9:0]         blk_y_o
);

  // Zig-zag scan index -> raster index {row, col}.
  localparam logic [3:0] ZZ [16] = '{
    4'd0, 4'd1, 4'd4, 4'd8, 4'd5, 4'd2, 4'd3, 4'd6,
    4'd9, 4'd12, 4'd13, 4'd10, 4'd7, 4'd11, 4'd14, 4'd15
  };

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  state_e             state_q;
  logic [3:0]         k_q;
  logic signed [14:0] coef_q [16];   // captured block, stored in scan order
  logic               seen_q;        // a nonzero has been met in this scan
  logic               t1_open_q;     // trailing-ones window still open
  logic               cnt_ready_q;
  logic               out_valid_q;
  logic [4:0]         tc_q;
  logic [1:0]         t1_q;
  logic [2:0]         signs_q;
  logic [3:0]         tz_q;
  logic signed [14:0] level_q [16];
  logic [3:0]         run_q [16];
  logic [9:0]         blk_x_q;
  logic [9:0]         blk_y_q;

  logic signed [14:0] scan_in [16];
  logic signed [14:0] cur_c;
  logic               cur_nz;
  logic               cur_one;
  logic [3:0]         run_idx;

  // Reorder the incoming raster block into scan order for capture.
  always_comb begin
    for (int k = 0; k < 16; k++) begin
      scan_in[k] = dctq_i[ZZ[k][3:2]][ZZ[k][1:0]];
    end
  end

  // Classify the coefficient under the scan pointer.
  always_comb begin
    cur_c   = coef_q[k_q];
    cur_nz  = (cur_c != 15'sd0);
    cur_one = (cur_c == 15'sd1) || (cur_c == -15'sd1);
    // Run of the most recently emitted level.
    run_idx = tc_q[3:0] - 4'd1;
  end

  // Control FSM with registered handshake and symbol outputs.
  always_ff @(posedge clk) begin
    if (rst || h264_reset) begin
      state_q     <= StIdle;
      k_q         <= 4'd0;
      seen_q      <= 1'b0;
      t1_open_q   <= 1'b0;
      cnt_ready_q <= 1'b1;
      out_valid_q <= 1'b0;
      tc_q        <= 5'd0;
      t1_q        <= 2'd0;
      signs_q     <= 3'd0;
      tz_q        <= 4'd0;
      blk_x_q     <= 10'd0;
      blk_y_q     <= 10'd0;
      for (int i = 0; i < 16; i++) begin
        level_q[i] <= '0;
        run_q[i]   <= '0;
      end
    end else begin
      case (state_q)
        StIdle: begin
          if (dctq_valid_i) begin
            state_q     <= StScan;
            k_q         <= 4'd15;
            seen_q      <= 1'b0;
            t1_open_q   <= 1'b1;
            cnt_ready_q <= 1'b0;
            tc_q        <= 5'd0;
            t1_q        <= 2'd0;
            signs_q     <= 3'd0;
            tz_q        <= 4'd0;
            blk_x_q     <= topleft_x_i;
            blk_y_q     <= topleft_y_i;
            for (int i = 0; i < 16; i++) begin
              coef_q[i]  <= scan_in[i];
              level_q[i] <= '0;
              run_q[i]   <= '0;
            end
          end
        end
        StScan: begin
          if (cur_nz) begin
            level_q[tc_q[3:0]] <= cur_c;
            tc_q               <= tc_q + 5'd1;
            seen_q             <= 1'b1;
            if (t1_open_q && cur_one && (t1_q != 2'd3)) begin
              signs_q[t1_q] <= cur_c[14];
              t1_q          <= t1_q + 2'd1;
            end else begin
              t1_open_q <= 1'b0;
            end
          end else if (seen_q) begin
            // Leading zeros (above the highest nonzero) are not coded.
            run_q[run_idx] <= run_q[run_idx] + 4'd1;
            tz_q           <= tz_q + 4'd1;
          end
          k_q <= k_q - 4'd1;
          if (k_q == 4'd0) begin
            state_q     <= StDone;
            out_valid_q <= 1'b1;
          end
        end
        StDone: begin
          if (out_ready_i) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            cnt_ready_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cnt_ready_o     = cnt_ready_q;
  assign out_valid_o     = out_valid_q;
  assign total_coeff_o   = tc_q;
  assign trailing_ones_o = t1_q;
  assign t1_signs_o      = signs_q;
  assign total_zeros_o   = tz_q;
  assign level_o         = level_q;
  assign run_o           = run_q;
  assign blk_x_o         = blk_x_q;
  assign blk_y_o         = blk_y_q;

endmodule

// File: tb/tb_cavlc_coeff_scan.sv
// Self-checking bench for cavlc_coeff_scan: directed table, reset/hold sequences and
// random blocks checked against a list-based CAVLC reference model.
module tb_cavlc_coeff_scan;

  logic               clk = 1'b0;
  logic               rst;
  logic               h264_reset;
  logic               dctq_valid;
  logic signed [14:0] dctq [0:3][0:3];
  logic [9:0]         tx;
  logic [9:0]         ty;
  logic               cnt_ready;
  logic               out_valid;
  logic               out_ready;
  logic [4:0]         tc;
  logic [1:0]         t1;
  logic [2:0]         signs;
  logic [3:0]         tz;
  logic signed [14:0] level [0:15];
  logic [3:0]         run [0:15];
  logic [9:0]         bx;
  logic [9:0]         by;

  always #5 clk = ~clk;

  cavlc_coeff_scan dut (
    .clk             (clk),
    .rst             (rst),
    .h264_reset      (h264_reset),
    .dctq_valid_i    (dctq_valid),
    .dctq_i          (dctq),
    .topleft_x_i     (tx),
    .topleft_y_i     (ty),
    .cnt_ready_o     (cnt_ready),
    .out_valid_o     (out_valid),
    .out_ready_i     (out_ready),
    .total_coeff_o   (tc),
    .trailing_ones_o (t1),
    .t1_signs_o      (signs),
    .total_zeros_o   (tz),
    .level_o         (level),
    .run_o           (run),
    .blk_x_o         (bx),
    .blk_y_o         (by)
  );

  // Raster index (row*4+col) of each zig-zag position.
  int zz [16] = '{0, 1, 4, 8, 5, 2, 3, 6, 9, 12, 13, 10, 7, 11, 14, 15};

  int n_checks = 0;
  int n_fail   = 0;

  logic signed [14:0] cur [16];   // block under test, raster order
  logic [4:0]         exp_tc;
  logic [1:0]         exp_t1;
  logic [2:0]         exp_signs;
  logic [3:0]         exp_tz;
  logic signed [14:0] exp_lvl [16];
  logic [3:0]         exp_run [16];
  logic [9:0]         exp_x;
  logic [9:0]         exp_y;

  typedef struct packed {
    logic [15:0][14:0] coef;      // raster order
    logic [4:0]        tc;
    logic [1:0]        t1;
    logic [2:0]        signs;
    logic [3:0]        tz;
    logic [15:0][14:0] lvl;
    logic [15:0][3:0]  run;
  } vec_t;

  vec_t vecs [5];
  localparam logic [14:0] M1 = 15'h7FFF;  // -1
  localparam logic [14:0] M7 = 15'h7FF9;  // -7

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  task automatic clear_exp();
    exp_tc = 0; exp_t1 = 0; exp_signs = 0; exp_tz = 0; exp_x = 0; exp_y = 0;
    for (int i = 0; i < 16; i++) begin
      exp_lvl[i] = 0;
      exp_run[i] = 0;
    end
  endtask

  // Reference: list the nonzeros in reverse scan order, then derive every symbol from it.
  task automatic model();
    int pos[$];
    int last;
    exp_tc = 0; exp_t1 = 0; exp_signs = 0; exp_tz = 0;
    for (int i = 0; i < 16; i++) begin
      exp_lvl[i] = 0;
      exp_run[i] = 0;
    end
    for (int k = 15; k >= 0; k--) if (cur[zz[k]] != 0) pos.push_back(k);
    exp_tc = 5'(pos.size());
    for (int i = 0; i < pos.size(); i++) begin
      exp_lvl[i] = cur[zz[pos[i]]];
      exp_run[i] = (i + 1 < pos.size()) ? 4'(pos[i] - pos[i + 1] - 1) : 4'(pos[i]);
    end
    if (pos.size() > 0) begin
      last   = pos[0];
      exp_tz = 4'(last + 1 - pos.size());
    end
    for (int i = 0; i < pos.size() && i < 3; i++) begin
      if (exp_lvl[i] == 1 || exp_lvl[i] == -1) begin
        exp_signs[i] = (exp_lvl[i] < 0);
        exp_t1       = exp_t1 + 2'd1;
      end else begin
        break;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, " total_coeff"}, 32'(tc), 32'(exp_tc));
    check({tag, " trailing_ones"}, 32'(t1), 32'(exp_t1));
    check({tag, " t1_signs"}, 32'(signs), 32'(exp_signs));
    check({tag, " total_zeros"}, 32'(tz), 32'(exp_tz));
    check({tag, " blk_x"}, 32'(bx), 32'(exp_x));
    check({tag, " blk_y"}, 32'(by), 32'(exp_y));
    for (int i = 0; i < 16; i++) begin
      check($sformatf("%s level[%0d]", tag, i), 32'(level[i]), 32'(exp_lvl[i]));
      check($sformatf("%s run[%0d]", tag, i), 32'(run[i]), 32'(exp_run[i]));
    end
  endtask

  task automatic check_idle(input string tag);
    clear_exp();
    check({tag, " cnt_ready"}, 32'(cnt_ready), 32'd1);
    check({tag, " out_valid"}, 32'(out_valid), 32'd0);
    check_outputs(tag);
  endtask

  task automatic drive_block(input logic [9:0] x, input logic [9:0] y);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) dctq[r][c] = cur[r * 4 + c];
    tx = x;
    ty = y;
    dctq_valid = 1'b1;
  endtask

  // Called away from the edge with dctq_valid high; returns 1 ns after the accept edge.
  task automatic accept(input string tag);
    int n;
    n = 0;
    while (!cnt_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, " ready before accept"}, 32'(cnt_ready), 32'd1);
    @(posedge clk);
    #1;
    dctq_valid = 1'b0;
    check({tag, " ready low after accept"}, 32'(cnt_ready), 32'd0);
    check({tag, " tc cleared on accept"}, 32'(tc), 32'd0);
  endtask

  // Counts edges after the accept edge until out_valid rises.
  task automatic wait_done(input string tag);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!out_valid && n < 40);
    check({tag, " latency"}, 32'(n), 32'd16);
  endtask

  task automatic release_blk(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, " out_valid drops"}, 32'(out_valid), 32'd0);
    check({tag, " ready returns"}, 32'(cnt_ready), 32'd1);
  endtask

  task automatic random_block();
    int dens;
    int v;
    dens = $urandom_range(0, 10);
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 9) < dens) begin
        case ($urandom_range(0, 3))
          0, 1:    v = 1;
          2:       v = $urandom_range(2, 20);
          default: v = $urandom_range(1, 16383);
        endcase
        cur[i] = 15'($urandom_range(0, 1) ? -v : v);
      end else begin
        cur[i] = 0;
      end
    end
  endtask

  initial begin
    int seen;

    // Directed vectors.
    for (int i = 0; i < 5; i++) vecs[i] = '0;
    // 1: spec example block
    vecs[1].coef[1] = 15'd3;  vecs[1].coef[4] = M1;  vecs[1].coef[2] = M1;
    vecs[1].coef[3] = 15'd1;  vecs[1].coef[9] = 15'd1;
    vecs[1].tc = 5'd5; vecs[1].t1 = 2'd3; vecs[1].signs = 3'b100; vecs[1].tz = 4'd4;
    vecs[1].lvl[0] = 15'd1; vecs[1].lvl[1] = 15'd1; vecs[1].lvl[2] = M1;
    vecs[1].lvl[3] = M1;    vecs[1].lvl[4] = 15'd3;
    vecs[1].run[0] = 4'd1;  vecs[1].run[2] = 4'd2;  vecs[1].run[4] = 4'd1;
    // 2: all 2, 3: all -1
    for (int j = 0; j < 16; j++) begin
      vecs[2].coef[j] = 15'd2; vecs[2].lvl[j] = 15'd2;
      vecs[3].coef[j] = M1;    vecs[3].lvl[j] = M1;
    end
    vecs[2].tc = 5'd16;
    vecs[3].tc = 5'd16; vecs[3].t1 = 2'd3; vecs[3].signs = 3'b111;
    // 4: lone -7 at (3,3)
    vecs[4].coef[15] = M7;
    vecs[4].tc = 5'd1; vecs[4].tz = 4'd15; vecs[4].lvl[0] = M7; vecs[4].run[0] = 4'd15;

    rst = 1'b1; h264_reset = 1'b0; dctq_valid = 1'b0; out_ready = 1'b0; tx = 0; ty = 0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) dctq[r][c] = 0;
    repeat (2) @(posedge clk);
    #1;
    check_idle("reset");
    @(negedge clk);
    rst = 1'b0;

    // Directed table.
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 16; j++) begin
        cur[j]     = vecs[i].coef[j];
        exp_lvl[j] = vecs[i].lvl[j];
        exp_run[j] = vecs[i].run[j];
      end
      exp_tc = vecs[i].tc; exp_t1 = vecs[i].t1; exp_signs = vecs[i].signs;
      exp_tz = vecs[i].tz;
      exp_x = 10'(i * 4 + 3); exp_y = 10'(i * 8 + 1);
      @(negedge clk);
      drive_block(exp_x, exp_y);
      accept($sformatf("vec%0d", i));
      wait_done($sformatf("vec%0d", i));
      check_outputs($sformatf("vec%0d", i));
      release_blk($sformatf("vec%0d", i));
    end

    // h264_reset in the middle of a scan discards the block.
    for (int j = 0; j < 16; j++) cur[j] = vecs[1].coef[j];
    @(negedge clk);
    drive_block(10'd100, 10'd200);
    accept("h264rst");
    repeat (10) @(posedge clk);
    @(negedge clk);
    h264_reset = 1'b1;
    @(posedge clk);
    #1;
    h264_reset = 1'b0;
    check_idle("h264rst");
    seen = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    check("h264rst no out_valid", 32'(seen), 32'd0);

    // rst while in DONE.
    random_block();
    cur[0] = 15'd5;
    @(negedge clk);
    drive_block(10'd7, 10'd9);
    accept("rstdone");
    wait_done("rstdone");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_idle("rstdone");

    // Hold DONE for 5 cycles with the next block already offered.
    random_block();
    model();
    exp_x = 10'd33; exp_y = 10'd44;
    @(negedge clk);
    drive_block(exp_x, exp_y);
    accept("holdA");
    wait_done("holdA");
    random_block();
    cur[15] = 15'd9;
    @(negedge clk);
    drive_block(10'd55, 10'd66);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check_outputs($sformatf("hold%0d", c));
      check($sformatf("hold%0d cnt_ready", c), 32'(cnt_ready), 32'd0);
      check($sformatf("hold%0d out_valid", c), 32'(out_valid), 32'd1);
    end
    release_blk("holdA");
    @(posedge clk);
    #1;
    dctq_valid = 1'b0;
    check("holdB accepted next cycle", 32'(cnt_ready), 32'd0);
    model();
    exp_x = 10'd55; exp_y = 10'd66;
    wait_done("holdB");
    check_outputs("holdB");
    release_blk("holdB");

    // Random blocks against the reference model.
    for (int b = 0; b < 40; b++) begin
      random_block();
      model();
      exp_x = 10'($urandom_range(0, 1023));
      exp_y = 10'($urandom_range(0, 1023));
      @(negedge clk);
      drive_block(exp_x, exp_y);
      accept($sformatf("rnd%0d", b));
      wait_done($sformatf("rnd%0d", b));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      check_outputs($sformatf("rnd%0d", b));
      release_blk($sformatf("rnd%0d", b));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
